// File: rtl/case_4_mul_pipe_hs_pkg.sv
// Shared definitions for the case_4 pipelined multiplier family.
//   - Output narrowing modes (wrap / saturate)
//   - Legal pipeline depth bounds
//   - Full-precision product width helper
package case_4_mul_pipe_hs_pkg;

  typedef enum logic {
    MODE_WRAP = 1'b0,
    MODE_SAT  = 1'b1
  } out_mode_e;

  localparam int NUM_STAGE_MIN = 1;
  localparam int NUM_STAGE_MAX = 8;

  // One extra bit so an unsigned*unsigned or mixed-sign product is exact
  // when carried as a signed value.
  function automatic int prod_width(input int w0, input int w1);
    return w0 + w1 + 1;
  endfunction

endpackage

// File: rtl/case_4_mul_pipe_hs_narrow_sat.sv
// Combinational scale-and-narrow stage for full-precision products.
//   din  : signed full-precision product (IN_WIDTH bits)
//   dout : product >>> SHIFT, wrapped or saturated to OUT_WIDTH bits
//   ovf  : result differs from the shifted full-precision value
module mul_narrow_sat
  import case_4_mul_pipe_hs_pkg::*;
#(
  parameter int IN_WIDTH  = 27,
  parameter int OUT_WIDTH = 26,
  parameter int SHIFT     = 0,
  parameter int OUT_MODE  = 0
) (
  input  logic signed [IN_WIDTH-1:0]  din,
  output logic        [OUT_WIDTH-1:0] dout,
  output logic                        ovf
);

  localparam int HW = IN_WIDTH - OUT_WIDTH + 1;

  logic signed [IN_WIDTH-1:0] s;
  logic        [HW-1:0]       head;
  logic                       fits;

  always_comb begin
    s    = din >>> SHIFT;
    // Value is representable iff every bit from the target sign bit upward
    // agrees.
    head = s[IN_WIDTH-1:OUT_WIDTH-1];
    fits = (&head) || !(|head);
    ovf  = !fits;
    if (fits || (OUT_MODE == int'(MODE_WRAP))) begin
      dout = s[OUT_WIDTH-1:0];
    end else if (s[IN_WIDTH-1]) begin
      dout = {1'b1, {(OUT_WIDTH-1){1'b0}}};
    end else begin
      dout = {1'b0, {(OUT_WIDTH-1){1'b1}}};
    end
  end

endmodule

// File: rtl/case_4_mul_pipe_hs.sv
// Pipelined signed/unsigned multiplier with valid/ready handshake on both
// sides and a wrap/saturate output stage.
//   ap_clk, ap_rst_n      : clock, async active-low reset
//   in_valid / in_ready   : operand handshake (din0, din1)
//   out_valid / out_ready : result handshake (dout, out_ovf)
// All stages advance together when the output is empty or being consumed.
module case_4_mul_pipe_hs
  import case_4_mul_pipe_hs_pkg::*;
#(
  parameter int ID          = 1,
  parameter int NUM_STAGE   = 3,
  parameter int din0_WIDTH  = 14,
  parameter int din1_WIDTH  = 12,
  parameter int dout_WIDTH  = 26,
  parameter int DIN0_SIGNED = 1,
  parameter int DIN1_SIGNED = 1,
  parameter int SHIFT       = 0,
  parameter int OUT_MODE    = 0
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [din0_WIDTH-1:0] din0,
  input  logic [din1_WIDTH-1:0] din1,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [dout_WIDTH-1:0] dout,
  output logic                  out_ovf
);

  localparam int PW = prod_width(din0_WIDTH, din1_WIDTH);

  if ((ID < 0) ||
      (NUM_STAGE < NUM_STAGE_MIN) || (NUM_STAGE > NUM_STAGE_MAX) ||
      (dout_WIDTH < 2) || (dout_WIDTH > din0_WIDTH + din1_WIDTH) ||
      (SHIFT < 0) || (SHIFT > din0_WIDTH + din1_WIDTH - 1) ||
      ((OUT_MODE != int'(MODE_WRAP)) && (OUT_MODE != int'(MODE_SAT))) ||
      ((DIN0_SIGNED != 0) && (DIN0_SIGNED != 1)) ||
      ((DIN1_SIGNED != 0) && (DIN1_SIGNED != 1))) begin : g_bad_param
    $error("case_4_mul_pipe_hs: illegal parameter combination");
  end

  logic                   adv;
  logic [NUM_STAGE-1:0]   vld_q;
  logic [NUM_STAGE-1:0]   vld_d;
  logic                   a_msb;
  logic                   b_msb;
  logic signed [PW-1:0]   a_ext;
  logic signed [PW-1:0]   b_ext;
  logic signed [PW-1:0]   prod;
  logic signed [PW-1:0]   narrow_in;
  logic [dout_WIDTH-1:0]  nar_dout;
  logic                   nar_ovf;
  logic [dout_WIDTH-1:0]  dout_q;
  logic                   ovf_q;

  assign adv       = !vld_q[NUM_STAGE-1] || out_ready;
  assign in_ready  = adv;
  assign out_valid = vld_q[NUM_STAGE-1];
  assign dout      = dout_q;
  assign out_ovf   = ovf_q;

  assign a_msb = (DIN0_SIGNED != 0) && din0[din0_WIDTH-1];
  assign b_msb = (DIN1_SIGNED != 0) && din1[din1_WIDTH-1];
  assign a_ext = {{(PW-din0_WIDTH){a_msb}}, din0};
  assign b_ext = {{(PW-din1_WIDTH){b_msb}}, din1};
  // The true product always fits in PW signed bits, so the truncated
  // PW x PW multiply is exact.
  assign prod  = a_ext * b_ext;

  always_comb begin
    vld_d    = vld_q << 1;
    vld_d[0] = in_valid;
  end

  // Stages 1..NUM_STAGE-1 carry the full product; the last stage holds the
  // narrowed result.
  for (genvar s = 1; s < NUM_STAGE; s++) begin : g_stage
    logic signed [PW-1:0] p_d;
    logic signed [PW-1:0] p_q;
    if (s == 1) begin : g_head
      assign p_d = prod;
    end else begin : g_body
      assign p_d = g_stage[s-1].p_q;
    end
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
        p_q <= '0;
      end else if (adv) begin
        p_q <= p_d;
      end
    end
  end

  if (NUM_STAGE == 1) begin : g_tail_direct
    assign narrow_in = prod;
  end else begin : g_tail_piped
    assign narrow_in = g_stage[NUM_STAGE-1].p_q;
  end

  mul_narrow_sat #(
    .IN_WIDTH (PW),
    .OUT_WIDTH(dout_WIDTH),
    .SHIFT    (SHIFT),
    .OUT_MODE (OUT_MODE)
  ) u_narrow (
    .din (narrow_in),
    .dout(nar_dout),
    .ovf (nar_ovf)
  );

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      vld_q  <= '0;
      dout_q <= '0;
      ovf_q  <= 1'b0;
    end else if (adv) begin
      vld_q  <= vld_d;
      dout_q <= nar_dout;
      ovf_q  <= nar_ovf;
    end
  end

endmodule
